// File: rtl/timer_pkg.sv
// Shared Timer definitions: edge-select codes, common widths and the edge
// qualification rule used by the event input conditioning stage.
package timer_pkg;

    localparam int TIMER_CNT_W  = 32;
    localparam int TIMER_PSC_W  = 8;
    localparam int TIMER_FILT_W = 4;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'b00,
        EDGE_FALLING = 2'b01,
        EDGE_BOTH    = 2'b10,
        EDGE_NONE    = 2'b11
    } edge_sel_e;

    // new_level is the level the filter is about to adopt: 1 means a rising edge.
    function automatic logic edge_qualifies(input edge_sel_e sel, input logic new_level);
        logic q;
        q = 1'b0;
        case (sel)
            EDGE_RISING:  q = new_level;
            EDGE_FALLING: q = ~new_level;
            EDGE_BOTH:    q = 1'b1;
            default:      q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/timer_input_filter.sv
// Synchroniser plus digital glitch filter for the Timer event pin. o_Change is
// high in the cycle the filtered level is about to flip to o_NewLevel.
module timer_input_filter #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_Enable,
    input  logic                    i_EventIn,
    input  logic [FILTER_DEPTH-1:0] i_FilterLen,
    output logic                    o_Level,
    output logic                    o_Change,
    output logic                    o_NewLevel
);

    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_level;
    logic [FILTER_DEPTH-1:0] r_cnt;
    logic                    w_s;
    logic                    w_change;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_change = i_Enable && (w_s != r_level) && (r_cnt == i_FilterLen);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_EventIn};
        end
    end

    // While disabled the level shadows the sample so re-enabling never fakes an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (!i_Enable) begin
            r_level <= w_s;
            r_cnt   <= '0;
        end else if (w_s == r_level) begin
            r_cnt   <= '0;
        end else if (w_change) begin
            r_level <= w_s;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_Level    = r_level;
    assign o_Change   = w_change;
    assign o_NewLevel = w_s;

endmodule

// File: rtl/timer_event_input.sv
// Timer event input stage: filtered pin -> edge select -> prescaler -> one-cycle
// event strobe, with a timestamp capture register read and acknowledged by software.
module timer_event_input
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_DEPTH = TIMER_FILT_W,
    parameter int PSC_DEPTH    = TIMER_PSC_W,
    parameter int TS_DEPTH     = TIMER_CNT_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_Enable,
    input  logic                    i_EventIn,
    input  logic [1:0]              i_Edge,
    input  logic [FILTER_DEPTH-1:0] i_FilterLen,
    input  logic [PSC_DEPTH-1:0]    i_Prescale,
    input  logic [TS_DEPTH-1:0]     i_Timestamp,
    input  logic                    i_CaptureAck,
    output logic                    o_EventLevel,
    output logic                    o_EventPulse,
    output logic [TS_DEPTH-1:0]     o_Capture,
    output logic                    o_CaptureValid,
    output logic                    o_CaptureOverrun
);

    logic                 w_change;
    logic                 w_new_level;
    logic                 w_qual;
    logic [PSC_DEPTH-1:0] r_psc;
    logic                 r_pulse;
    logic [TS_DEPTH-1:0]  r_ts;
    logic [TS_DEPTH-1:0]  r_capture;
    logic                 r_valid;
    logic                 r_overrun;

    timer_input_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_DEPTH (FILTER_DEPTH)
    ) u_filter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_Enable    (i_Enable),
        .i_EventIn   (i_EventIn),
        .i_FilterLen (i_FilterLen),
        .o_Level     (o_EventLevel),
        .o_Change    (w_change),
        .o_NewLevel  (w_new_level)
    );

    assign w_qual = w_change && edge_qualifies(edge_sel_e'(i_Edge), w_new_level);

    // >= lets a lowered prescale fire on the very next qualifying edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_psc   <= '0;
            r_pulse <= 1'b0;
            r_ts    <= '0;
        end else if (!i_Enable) begin
            r_psc   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_qual) begin
                if (r_psc >= i_Prescale) begin
                    r_pulse <= 1'b1;
                    r_psc   <= '0;
                    r_ts    <= i_Timestamp;
                end else begin
                    r_psc   <= r_psc + 1'b1;
                end
            end
        end
    end

    // Capture handshake: o_CaptureValid holds until a one-cycle i_CaptureAck;
    // an ack coinciding with a new event hands the slot straight to that event.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_capture <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (r_pulse) begin
            if (!r_valid || i_CaptureAck) begin
                r_capture <= r_ts;
                r_valid   <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (i_CaptureAck) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign o_EventPulse     = r_pulse;
    assign o_Capture        = r_capture;
    assign o_CaptureValid   = r_valid;
    assign o_CaptureOverrun = r_overrun;

endmodule
